// File: rtl/paksnd.sv
// Packet transmitter: buffers loaded packets in a small circular FIFO, appends a
// redundancy nibble, and sends each one over a 4-phase req/ack channel.
module paksnd #(
   parameter int ASZ = 6,
   parameter int DSZ = 4,
   parameter int RSZ = 4,
   parameter int PSZ = 2*ASZ+DSZ+RSZ,
   parameter int FSZ = 2
) (
   input  logic           i_clk,
   input  logic           i_rstn,
   input  logic           i_put,
   input  logic [ASZ-1:0] i_src,
   input  logic [ASZ-1:0] i_dst,
   input  logic [DSZ-1:0] i_dat,
   output logic           o_full,
   output logic           o_empty,
   output logic [FSZ:0]   o_count,
   output logic           snd0_req,
   input  logic           snd0_ack,
   output logic [PSZ-1:0] snd0_data,
   output logic [1:0]     o_err,
   output logic           has_err,
   output logic [1:0]     o_state
);

   // Channel protocol: req rises with data already stable, the receiver raises ack,
   // req falls, the receiver drops ack; only then may the next req rise.
   localparam int EW = ((ASZ > DSZ) ? ASZ : DSZ) + 2;
   localparam int DEPTH = 1 << FSZ;
   localparam logic [FSZ:0] FULL_CNT = (FSZ+1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_ACKLO = 2'd2
   } state_t;

   state_t          state;
   logic [PSZ-1:0]  mem [DEPTH];
   logic [FSZ-1:0]  wr_ptr;
   logic [FSZ-1:0]  rd_ptr;
   logic [FSZ:0]    count;
   logic [EW-1:0]   sum_w;
   logic [RSZ-1:0]  red;
   logic            push;
   logic            pop;

   assign sum_w   = EW'(i_src) + EW'(i_dst) + EW'(i_dat);
   assign red     = sum_w[RSZ-1:0];
   assign o_full  = (count == FULL_CNT);
   assign o_empty = (count == '0);
   assign o_count = count;
   assign has_err = |o_err;
   assign o_state = state;
   // A put against a full FIFO is dropped even when a pop frees a slot that cycle.
   assign push    = i_put && !o_full;

   always_comb begin
      pop = 1'b0;
      if (!o_empty) begin
         case (state)
            ST_IDLE:  pop = 1'b1;
            ST_ACKLO: pop = !snd0_ack;
            default:  pop = 1'b0;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= {i_src, i_dst, i_dat, red};
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state     <= ST_IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         snd0_req  <= 1'b0;
         snd0_data <= '0;
         o_err     <= 2'b00;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (i_put && o_full) o_err[0] <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (snd0_ack) o_err[1] <= 1'b1;
               if (pop) begin
                  snd0_data <= mem[rd_ptr];
                  snd0_req  <= 1'b1;
                  state     <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (snd0_ack) begin
                  snd0_req <= 1'b0;
                  state    <= ST_ACKLO;
               end
            end
            ST_ACKLO: begin
               if (!snd0_ack) begin
                  if (pop) begin
                     snd0_data <= mem[rd_ptr];
                     snd0_req  <= 1'b1;
                     state     <= ST_REQ;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_paksnd.sv
// Bench for paksnd: randomized loads, a behavioural receiver, and a scoreboard
// queue checked whenever the transmitter raises req.
module tb_paksnd;
   localparam int ASZ = 6;
   localparam int DSZ = 4;
   localparam int RSZ = 4;
   localparam int PSZ = 20;
   localparam int FSZ = 2;

   logic           i_clk = 1'b0;
   logic           i_rstn;
   logic           i_put;
   logic [ASZ-1:0] i_src;
   logic [ASZ-1:0] i_dst;
   logic [DSZ-1:0] i_dat;
   logic           o_full;
   logic           o_empty;
   logic [FSZ:0]   o_count;
   logic           snd0_req;
   logic           snd0_ack;
   logic [PSZ-1:0] snd0_data;
   logic [1:0]     o_err;
   logic           has_err;
   logic [1:0]     o_state;

   paksnd dut (
      .i_clk(i_clk), .i_rstn(i_rstn), .i_put(i_put), .i_src(i_src), .i_dst(i_dst),
      .i_dat(i_dat), .o_full(o_full), .o_empty(o_empty), .o_count(o_count),
      .snd0_req(snd0_req), .snd0_ack(snd0_ack), .snd0_data(snd0_data),
      .o_err(o_err), .has_err(has_err), .o_state(o_state)
   );

   // clock / reset
   always #5 i_clk = ~i_clk;

   int errors = 0;
   int checks = 0;
   logic [PSZ-1:0] exp_q[$];
   int pushed = 0;
   int rises = 0;
   logic [1:0] exp_err = 2'b00;
   int cyc = 0;
   int rise_cyc[$];
   bit rx_en = 1'b0;
   int rx_dly = 0;
   int rx_cnt = 0;
   logic req_at_edge, ack_at_edge;
   logic [PSZ-1:0] held;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [PSZ-1:0] ref_pkt(input int s, input int d, input int t);
      int r;
      r = (s + d + t) % (1 << RSZ);
      return PSZ'((s << (ASZ+DSZ+RSZ)) + (d << (DSZ+RSZ)) + (t << RSZ) + r);
   endfunction

   // monitor + receiver: sample at the edge, compare just after it
   always @(posedge i_clk) begin
      req_at_edge = snd0_req;
      ack_at_edge = snd0_ack;
      cyc++;
      #1;
      if (ack_at_edge) chk("no_req_while_ack", snd0_req, 1'b0);
      if (snd0_req && !req_at_edge) begin
         rises++;
         rise_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: data %0h with empty scoreboard", snd0_data);
         end else begin
            chk("pkt_data", snd0_data, exp_q.pop_front());
         end
         held = snd0_data;
      end else if (snd0_req && req_at_edge) begin
         chk("data_stable", snd0_data, held);
      end
      if (rx_en) begin
         if (snd0_req !== snd0_ack) begin
            if (rx_cnt >= rx_dly) begin
               snd0_ack = snd0_req;
               rx_cnt = 0;
            end else begin
               rx_cnt++;
            end
         end else begin
            rx_cnt = 0;
         end
      end
   end

   // driver: one call per cycle, checks occupancy flags then drives the load port
   task automatic step(input bit put, input int s, input int d, input int t);
      int occ;
      @(negedge i_clk);
      occ = pushed - rises;
      chk("count", o_count, occ);
      chk("empty", o_empty, occ == 0);
      chk("full", o_full, occ == 4);
      if (put) begin
         if (occ < 4) begin
            exp_q.push_back(ref_pkt(s, d, t));
            pushed++;
         end else begin
            exp_err[0] = 1'b1;
         end
      end
      i_put = put;
      i_src = ASZ'(s);
      i_dst = ASZ'(d);
      i_dat = DSZ'(t);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0);
   endtask

   task automatic drain(input int limit);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || snd0_req || snd0_ack) && n < limit) begin
         step(1'b0, 0, 0, 0);
         n++;
      end
      checks++;
      if (n >= limit) begin
         errors++;
         $display("FAIL drain_timeout: %0d packets still expected", exp_q.size());
      end
   endtask

   initial begin
      i_rstn = 1'b0; i_put = 1'b0; i_src = '0; i_dst = '0; i_dat = '0; snd0_ack = 1'b0;
      #12;
      chk("rst_req", snd0_req, 1'b0);
      chk("rst_data", snd0_data, 20'h0);
      chk("rst_count", o_count, 3'd0);
      chk("rst_empty", o_empty, 1'b1);
      chk("rst_err", o_err, 2'b00);
      chk("rst_state", o_state, 2'd0);
      @(negedge i_clk);
      i_rstn = 1'b1;

      // single packet, slow receiver
      rx_en = 1'b1; rx_dly = 3;
      step(1'b1, 3, 2, 5);
      @(posedge i_clk); #2;
      chk("t1_req_early", snd0_req, 1'b0);
      chk("t1_not_empty", o_empty, 1'b0);
      i_put = 1'b0;
      @(posedge i_clk); #2;
      chk("t1_req_up", snd0_req, 1'b1);
      chk("t1_data", snd0_data, 20'h0C25A);
      idle(14);
      chk("t1_state", o_state, 2'd0);
      chk("t1_err", o_err, 2'b00);

      // overfill with a stalled receiver, then drain
      rx_en = 1'b0; snd0_ack = 1'b0;
      for (int i = 1; i <= 6; i++) step(1'b1, $urandom_range(0, 63), $urandom_range(0, 63), i);
      idle(1);
      chk("t2_full", o_full, 1'b1);
      chk("t2_err", o_err, exp_err);
      chk("t2_has_err", has_err, 1'b1);
      rx_en = 1'b1; rx_dly = 0;
      drain(100);

      // back-to-back with a one-cycle registered receiver: 4-cycle period
      rx_dly = 1;
      rise_cyc.delete();
      for (int i = 0; i < 3; i++) step(1'b1, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 15));
      idle(1);
      drain(100);
      chk("t3_rises", rise_cyc.size(), 3);
      if (rise_cyc.size() == 3) begin
         chk("t3_period1", rise_cyc[1] - rise_cyc[0], 4);
         chk("t3_period2", rise_cyc[2] - rise_cyc[1], 4);
      end

      // random traffic, including drops and pointer wrap
      for (int i = 0; i < 120; i++) begin
         if ((i % 10) == 0) rx_dly = $urandom_range(0, 3);
         step($urandom_range(0, 99) < 65, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 15));
      end
      idle(1);
      drain(200);
      chk("t4_err", o_err, exp_err);

      // spurious ack in idle
      rx_en = 1'b0;
      idle(2);
      @(negedge i_clk); snd0_ack = 1'b1;
      @(negedge i_clk); snd0_ack = 1'b0;
      exp_err[1] = 1'b1;
      idle(3);
      chk("t5_req", snd0_req, 1'b0);
      chk("t5_state", o_state, 2'd0);
      chk("t5_err", o_err, exp_err);

      // reset during a handshake with packets queued
      for (int i = 0; i < 3; i++) step(1'b1, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 15));
      idle(2);
      chk("t6_req_before", snd0_req, 1'b1);
      @(posedge i_clk); #3;
      i_rstn = 1'b0;
      #1;
      chk("t6_req", snd0_req, 1'b0);
      chk("t6_empty", o_empty, 1'b1);
      chk("t6_err", o_err, 2'b00);
      exp_q.delete(); pushed = 0; rises = 0; exp_err = 2'b00;
      @(negedge i_clk);
      i_rstn = 1'b1;
      idle(5);
      chk("t6_no_req", snd0_req, 1'b0);
      rx_en = 1'b1; rx_dly = 0;
      step(1'b1, 63, 63, 15);
      idle(1);
      drain(100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
